// File: rtl/lfsr_encrypter.sv
// LFSR stream encrypter: reads plaintext, prepends an underscore preamble,
// XORs a 6-bit keystream and writes a 64-byte ciphertext block.
module lfsr_encrypter #(
  parameter int OUT_BASE = 64,
  parameter int NBYTES   = 64,
  parameter int PRE_MIN  = 7,
  parameter int PRE_MAX  = 12
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  input  logic [2:0] pat_sel,
  input  logic [5:0] seed,
  input  logic [3:0] pre_len,
  output logic [7:0] raddr,
  input  logic [7:0] data_out,
  output logic       wr_en,
  output logic [7:0] waddr,
  output logic [7:0] data_in,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE, LOAD, RUN, DONE
  } state_t;

  localparam logic [7:0] BASE  = 8'(OUT_BASE);
  localparam logic [6:0] KLAST = 7'(NBYTES - 1);
  localparam logic [3:0] PMIN  = 4'(PRE_MIN);
  localparam logic [3:0] PMAX  = 4'(PRE_MAX);
  localparam logic [7:0] UNDER = 8'h5F;

  state_t     state_q, state_d;
  logic [6:0] k_q, k_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [2:0] pat_q, pat_d;
  logic [5:0] seed_q, seed_d;
  logic [3:0] plen_q, plen_d;

  logic [5:0] taps;
  logic [3:0] plen_clamp;
  logic [7:0] k8;
  logic [7:0] pre8;
  logic       in_pre;
  logic [7:0] plain;

  always_comb begin
    unique case (pat_q)
      3'd0:    taps = 6'h21;
      3'd1:    taps = 6'h2D;
      3'd2:    taps = 6'h30;
      3'd3:    taps = 6'h33;
      3'd4:    taps = 6'h36;
      3'd5:    taps = 6'h39;
      default: taps = 6'h21;
    endcase
  end

  always_comb begin
    if (pre_len < PMIN)
      plen_clamp = PMIN;
    else if (pre_len > PMAX)
      plen_clamp = PMAX;
    else
      plen_clamp = pre_len;
  end

  assign k8     = {1'b0, k_q};
  assign pre8   = {4'b0000, plen_q};
  assign in_pre = (k8 < pre8);
  assign plain  = in_pre ? UNDER : data_out;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lfsr_d  = lfsr_q;
    pat_d   = pat_q;
    seed_d  = seed_q;
    plen_d  = plen_q;
    raddr   = 8'h00;
    wr_en   = 1'b0;
    waddr   = 8'h00;
    data_in = 8'h00;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          pat_d   = (pat_sel > 3'd5) ? 3'd0 : pat_sel;
          // an all-zero seed would lock the LFSR at zero
          seed_d  = (seed == 6'd0) ? 6'h01 : seed;
          plen_d  = plen_clamp;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        lfsr_d  = seed_q;
        k_d     = 7'd0;
        state_d = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        waddr   = BASE + k8;
        data_in = plain ^ {2'b00, lfsr_q};
        raddr   = in_pre ? 8'h00 : (k8 - pre8);
        lfsr_d  = {lfsr_q[4:0], ^(lfsr_q & taps)};
        k_d     = k_q + 7'd1;
        if (k_q == KLAST)
          state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= IDLE;
      k_q     <= 7'd0;
      lfsr_q  <= 6'd0;
      pat_q   <= 3'd0;
      seed_q  <= 6'd0;
      plen_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lfsr_q  <= lfsr_d;
      pat_q   <= pat_d;
      seed_q  <= seed_d;
      plen_q  <= plen_d;
    end
  end

endmodule

// File: tb/tb_lfsr_encrypter.sv
// Bench for lfsr_encrypter: memory model, keystream reference model,
// and an independent decrypter used for round-trip checks.
module tb_lfsr_encrypter;

  logic       clk;
  logic       init_n;
  logic       start;
  logic [2:0] pat_sel;
  logic [5:0] seed;
  logic [3:0] pre_len;
  logic [7:0] raddr;
  logic [7:0] data_out;
  logic       wr_en;
  logic [7:0] waddr;
  logic [7:0] data_in;
  logic       busy;
  logic       done;

  lfsr_encrypter dut (
    .clk      (clk),
    .init_n   (init_n),
    .start    (start),
    .pat_sel  (pat_sel),
    .seed     (seed),
    .pre_len  (pre_len),
    .raddr    (raddr),
    .data_out (data_out),
    .wr_en    (wr_en),
    .waddr    (waddr),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done)
  );

  logic [7:0] mem [256];
  bit         wrote [256];
  logic [7:0] pt [64];
  logic [7:0] exp_ct [64];
  logic [7:0] dec [64];
  logic [5:0] TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
  int nwr, ndone;
  int pass_n = 0;
  int tot_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_out = mem[raddr];

  // memory write port and event counters
  always @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] = data_in;
      wrote[waddr] = 1'b1;
      nwr = nwr + 1;
    end
    if (done) ndone = ndone + 1;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tot_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, req);
  endtask

  function automatic logic [5:0] step(input logic [5:0] s,
                                      input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  // expected block from effective pattern/seed/preamble length
  task automatic build(input int pe, input logic [5:0] se, input int p);
    logic [5:0] s;
    logic [7:0] pk;
    s = se;
    for (int k = 0; k < 64; k++) begin
      pk = (k < p) ? 8'h5F : pt[k - p];
      exp_ct[k] = pk ^ {2'b00, s};
      s = step(s, TAPS[pe]);
    end
  endtask

  task automatic build_raw(input logic [2:0] p, input logic [5:0] s,
                           input logic [3:0] l);
    int pl;
    pl = (l < 7) ? 7 : ((l > 12) ? 12 : int'(l));
    build((p > 5) ? 0 : int'(p), (s == 0) ? 6'h01 : s, pl);
  endtask

  task automatic blk_check(input string nm);
    int bad;
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (mem[64 + k] !== exp_ct[k]) bad++;
    check(nm, bad, 0);
  endtask

  task automatic load_pt(input bit rnd);
    for (int i = 0; i < 64; i++) begin
      pt[i] = rnd ? 8'($urandom) : 8'(i * 7 + 3);
      mem[i] = pt[i];
    end
    if (pt[0] == 8'h5F) begin
      pt[0] = 8'h41;
      mem[0] = 8'h41;
    end
  endtask

  task automatic clear_out();
    for (int i = 64; i < 128; i++) mem[i] = 8'h00;
  endtask

  // independent receiver: find the pattern whose keystream turns the
  // first 7 bytes into underscores, then strip the preamble
  task automatic decrypt(output int found, output int q);
    logic [5:0] s;
    bit ok;
    found = -1;
    q = 0;
    for (int t = 0; t < 6; t++) begin
      if (found < 0) begin
        s = mem[64][5:0] ^ 6'h1F;
        ok = 1'b1;
        for (int k = 0; k < 7; k++) begin
          if ((mem[64 + k] ^ {2'b00, s}) != 8'h5F) ok = 1'b0;
          s = step(s, TAPS[t]);
        end
        if (ok) found = t;
      end
    end
    if (found >= 0) begin
      s = mem[64][5:0] ^ 6'h1F;
      for (int k = 0; k < 64; k++) begin
        dec[k] = mem[64 + k] ^ {2'b00, s};
        s = step(s, TAPS[found]);
      end
      while (q < 12 && dec[q] == 8'h5F) q++;
    end
  endtask

  // caller must be at a negedge; returns at the first idle negedge
  task automatic run(input logic [2:0] p, input logic [5:0] s,
                     input logic [3:0] l, input int glitch,
                     input int abort_c, output int cyc);
    nwr = 0;
    ndone = 0;
    foreach (wrote[i]) wrote[i] = 1'b0;
    start = 1'b1;
    pat_sel = p;
    seed = s;
    pre_len = l;
    @(negedge clk);
    start = 1'b0;
    pat_sel = 3'($urandom);
    seed = 6'($urandom);
    pre_len = 4'($urandom);
    cyc = -1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      start = (c == glitch);
      if (c == glitch) begin
        pat_sel = 3'd3;
        seed = 6'h2B;
      end
      if (c == abort_c) begin
        init_n = 1'b0;
        #1;
        check("abort_wr_en", wr_en, 0);
        check("abort_busy", busy, 0);
        cyc = -2;
        break;
      end
      if (done) begin
        cyc = c;
        break;
      end
    end
    start = 1'b0;
    if (cyc > 0) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
  endtask

  typedef struct {
    logic [2:0] pat;
    logic [5:0] seed;
    logic [3:0] plen;
    int         epat;
    logic [5:0] eseed;
    int         ep;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t tv [4];

  initial begin
    int cyc, found, q, bad;
    logic [2:0] rp;
    logic [5:0] rs;
    logic [3:0] rl;

    tv[0] = '{3'd0, 6'h01, 4'd8,  0, 6'h01, 8,  8'h5E, 8'h5C};
    tv[1] = '{3'd7, 6'h00, 4'd3,  0, 6'h01, 7,  8'h5E, 8'h5C};
    tv[2] = '{3'd2, 6'h3F, 4'd15, 2, 6'h3F, 12, 8'h60, 8'h61};
    tv[3] = '{3'd5, 6'h2A, 4'd0,  5, 6'h2A, 7,  8'h75, 8'h4B};

    foreach (mem[i]) mem[i] = 8'h00;
    nwr = 0;
    ndone = 0;
    init_n = 1'b1;
    start = 1'b0;
    pat_sel = 3'd0;
    seed = 6'd0;
    pre_len = 4'd0;
    #1 init_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_raddr", raddr, 0);
    check("rst_waddr", waddr, 0);
    check("rst_data_in", data_in, 0);
    @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);

    // table vectors: preamble, clamps, illegal pattern/seed
    load_pt(1'b0);
    for (int i = 0; i < 4; i++) begin
      clear_out();
      run(tv[i].pat, tv[i].seed, tv[i].plen, 0, 0, cyc);
      check($sformatf("tv%0d_latency", i), cyc, 65);
      check($sformatf("tv%0d_e0", i), mem[64], tv[i].e0);
      check($sformatf("tv%0d_e1", i), mem[65], tv[i].e1);
      check($sformatf("tv%0d_nwr", i), nwr, 64);
      check($sformatf("tv%0d_ndone", i), ndone, 1);
      build(tv[i].epat, tv[i].eseed, tv[i].ep);
      blk_check($sformatf("tv%0d_block", i));
    end

    // round trip through the receiver model for every pattern
    for (int t = 0; t < 6; t++) begin
      load_pt(1'b1);
      clear_out();
      rs = 6'($urandom_range(63, 1));
      run(3'(t), rs, 4'd8, 0, 0, cyc);
      check($sformatf("rt%0d_latency", t), cyc, 65);
      build(t, rs, 8);
      blk_check($sformatf("rt%0d_block", t));
      decrypt(found, q);
      check($sformatf("rt%0d_foundit", t), found, t);
      bad = 0;
      for (int i = 0; i < 56; i++)
        if (q + i > 63 || dec[q + i] !== pt[i]) bad++;
      check($sformatf("rt%0d_plain", t), bad, 0);
    end

    // fully random inputs including illegal values
    for (int r = 0; r < 4; r++) begin
      load_pt(1'b1);
      clear_out();
      rp = 3'($urandom);
      rs = 6'($urandom);
      rl = 4'($urandom);
      run(rp, rs, rl, 0, 0, cyc);
      build_raw(rp, rs, rl);
      blk_check($sformatf("rnd%0d_block", r));
      check($sformatf("rnd%0d_nwr", r), nwr, 64);
    end

    // start re-pulsed at k=20 must be ignored
    load_pt(1'b1);
    clear_out();
    run(3'd1, 6'h15, 4'd9, 21, 0, cyc);
    check("glitch_latency", cyc, 65);
    check("glitch_ndone", ndone, 1);
    check("glitch_nwr", nwr, 64);
    build_raw(3'd1, 6'h15, 4'd9);
    blk_check("glitch_block");

    // asynchronous reset while k=30 is being presented
    load_pt(1'b1);
    clear_out();
    run(3'd4, 6'h0F, 4'd10, 0, 31, cyc);
    check("abort_path", cyc, -2);
    repeat (2) @(negedge clk);
    check("abort_ndone", ndone, 0);
    bad = 0;
    for (int a = 95; a < 128; a++) if (wrote[a]) bad++;
    check("abort_tail_unwritten", bad, 0);
    build_raw(3'd4, 6'h0F, 4'd10);
    bad = 0;
    for (int k = 0; k < 30; k++)
      if (!wrote[64 + k] || mem[64 + k] !== exp_ct[k]) bad++;
    check("abort_head_written", bad, 0);
    init_n = 1'b1;
    @(negedge clk);
    clear_out();
    run(3'd4, 6'h0F, 4'd10, 0, 0, cyc);
    check("after_abort_latency", cyc, 65);
    blk_check("after_abort_block");

    // back-to-back runs: second block overwrites the first
    load_pt(1'b1);
    clear_out();
    run(3'd3, 6'h11, 4'd8, 0, 0, cyc);
    build_raw(3'd3, 6'h11, 4'd8);
    blk_check("b2b_first_block");
    run(3'd3, 6'h2E, 4'd8, 0, 0, cyc);
    check("b2b_latency", cyc, 65);
    check("b2b_nwr", nwr, 64);
    build_raw(3'd3, 6'h2E, 4'd8);
    blk_check("b2b_second_block");

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
